// File: rtl/stream_packer_pkg.sv
// Shared types and constants for the stream packer.
package stream_packer_pkg;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } pack_state_e;

  localparam int unsigned OvfCountWidth = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; write-while-full is accepted only with a same-edge read.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = rd_en && !empty;
  assign push  = wr_en && (!full || pop);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/stream_packer.sv
// Packs sample pairs into double-width AXI-Stream words with framing and a sticky overflow flag.
// Optional macro STREAM_PACKER_OVF_COUNT_EN adds a saturating dropped-word counter ovf_count.
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FRAME_LEN  = 256
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    ovf_clr,
  output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    overflow
`ifdef STREAM_PACKER_OVF_COUNT_EN
  ,
  output logic [OvfCountWidth-1:0] ovf_count
`endif
);

  localparam int unsigned CntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  pack_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]   low_q;
  logic                    low_we, word_wr;
  logic                    fifo_full, fifo_empty, pop, drop;
  logic [2*DATA_WIDTH-1:0] fifo_dout;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    last_cnt;
  logic                    overflow_q, overflow_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= LOW;
    else          state_q <= state_d;
  end

  // Any cycle without enable abandons a held low half.
  always_comb begin
    state_d = LOW;
    if (enable) state_d = (state_q == LOW) ? HIGH : LOW;
  end

  always_comb begin
    low_we  = enable && (state_q == LOW);
    word_wr = enable && (state_q == HIGH);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)    low_q <= '0;
    else if (low_we) low_q <= s_data;
  end

  sync_fifo #(
    .WIDTH(2 * DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i (aclk),
    .rst_ni(aresetn),
    .wr_en (word_wr),
    .din   ({s_data, low_q}),
    .full  (fifo_full),
    .rd_en (m_axis_tready),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_dout;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign drop          = word_wr && fifo_full && !pop;
  assign last_cnt      = (cnt_q == CntW'(FRAME_LEN - 1));
  assign m_axis_tlast  = m_axis_tvalid && last_cnt;

  always_comb begin
    cnt_d = cnt_q;
    if (pop) cnt_d = last_cnt ? '0 : cnt_q + CntW'(1);
  end

  // A drop on the same edge as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

`ifdef STREAM_PACKER_OVF_COUNT_EN
  logic [OvfCountWidth-1:0] ovf_count_q, ovf_count_d;

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_clr)                ovf_count_d = drop ? OvfCountWidth'(1) : '0;
    else if (drop && !(&ovf_count_q)) ovf_count_d = ovf_count_q + OvfCountWidth'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ovf_count_q <= '0;
    else          ovf_count_q <= ovf_count_d;
  end

  assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Directed self-checking bench for stream_packer (DATA_WIDTH=16, FIFO_DEPTH=8, FRAME_LEN=4).
module tb_stream_packer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [15:0] s_data;
  logic        ovf_clr;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        overflow;
`ifdef STREAM_PACKER_OVF_COUNT_EN
  logic [15:0] ovf_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int k;

  always #5 aclk = ~aclk;

  stream_packer #(
    .DATA_WIDTH(16),
    .FIFO_DEPTH(8),
    .FRAME_LEN (4)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .enable       (enable),
    .s_data       (s_data),
    .ovf_clr      (ovf_clr),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .overflow     (overflow)
`ifdef STREAM_PACKER_OVF_COUNT_EN
    ,
    .ovf_count    (ovf_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    step();
    step();
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    enable = 1'b0;
    s_data = '0;
    ovf_clr = 1'b0;
    m_axis_tready = 1'b0;
    #2;
    chk("init_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("init_tdata", 64'(m_axis_tdata), 64'd0);
    chk("init_overflow", 64'(overflow), 64'd0);
`ifdef STREAM_PACKER_OVF_COUNT_EN
    chk("init_ovf_count", 64'(ovf_count), 64'd0);
`endif
    step();
    step();
    aresetn = 1'b1;

    // Basic pair: 14 then -29
    enable = 1'b1; s_data = 16'd14; m_axis_tready = 1'b1;
    step();
    chk("pair_no_early_valid", 64'(m_axis_tvalid), 64'd0);
    s_data = 16'hFFE3;
    step();
    chk("pair_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("pair_tdata", 64'(m_axis_tdata), 64'hFFE3000E);
    chk("pair_tlast", 64'(m_axis_tlast), 64'd0);
    enable = 1'b0;
    step();
    chk("pair_one_cycle", 64'(m_axis_tvalid), 64'd0);

    // Lone sample is discarded and FSM returns to LOW
    enable = 1'b1; s_data = 16'd7;
    step();
    enable = 1'b0;
    step();
    chk("lone_no_word", 64'(m_axis_tvalid), 64'd0);
    step();
    chk("lone_no_word2", 64'(m_axis_tvalid), 64'd0);
    enable = 1'b1; s_data = 16'hA5A5;
    step();
    s_data = 16'h5A5A;
    step();
    enable = 1'b0;
    chk("lone_next_pair", 64'(m_axis_tdata), 64'h5A5AA5A5);
    step();

    // Framing with continuous enable
    do_reset();
    enable = 1'b1; m_axis_tready = 1'b1;
    k = 0;
    for (int i = 0; i < 24; i++) begin
      s_data = 16'(i);
      step();
      if (m_axis_tvalid) begin
        chk("frame_tdata", 64'(m_axis_tdata), 64'({16'(2*k+1), 16'(2*k)}));
        chk("frame_tlast", 64'(m_axis_tlast), 64'((k % 4) == 3));
        k++;
      end
    end
    enable = 1'b0;
    chk("frame_word_count", 64'(k), 64'd12);
    step();
    chk("frame_drained", 64'(m_axis_tvalid), 64'd0);

    // Overflow: 20 samples into depth 8 with tready low
    do_reset();
    enable = 1'b1; m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_data = 16'(16'h0100 + i);
      step();
    end
    enable = 1'b0;
    chk("ovf_flag", 64'(overflow), 64'd1);
`ifdef STREAM_PACKER_OVF_COUNT_EN
    chk("ovf_count2", 64'(ovf_count), 64'd2);
`endif
    m_axis_tready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("drain_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("drain_tdata", 64'(m_axis_tdata),
          64'({16'(16'h0100 + 2*j + 1), 16'(16'h0100 + 2*j)}));
      chk("drain_tlast", 64'(m_axis_tlast), 64'((j % 4) == 3));
      step();
    end
    chk("drain_empty", 64'(m_axis_tvalid), 64'd0);
    chk("drain_ovf_sticky", 64'(overflow), 64'd1);

    // Refill to full; clear colliding with a drop, then a clean clear
    m_axis_tready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_data = 16'(16'h0200 + i);
      step();
    end
    s_data = 16'h0BAD;
    step();
    s_data = 16'h0BEE; ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0; enable = 1'b0;
    chk("clr_vs_drop", 64'(overflow), 64'd1);
`ifdef STREAM_PACKER_OVF_COUNT_EN
    chk("clr_vs_drop_cnt", 64'(ovf_count), 64'd1);
`endif
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_clean", 64'(overflow), 64'd0);
`ifdef STREAM_PACKER_OVF_COUNT_EN
    chk("clr_clean_cnt", 64'(ovf_count), 64'd0);
`endif

    // Write into full FIFO with simultaneous pop is accepted
    enable = 1'b1; s_data = 16'h1111;
    step();
    s_data = 16'h2222; m_axis_tready = 1'b1;
    step();
    enable = 1'b0; m_axis_tready = 1'b0;
    chk("full_pop_no_ovf", 64'(overflow), 64'd0);
    m_axis_tready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("full_pop_tvalid", 64'(m_axis_tvalid), 64'd1);
      if (j < 7)
        chk("full_pop_tdata", 64'(m_axis_tdata),
            64'({16'(16'h0200 + 2*(j+1) + 1), 16'(16'h0200 + 2*(j+1))}));
      else
        chk("full_pop_tdata_last", 64'(m_axis_tdata), 64'h22221111);
      chk("full_pop_tlast", 64'(m_axis_tlast), 64'(((j + 1) % 4) == 3));
      step();
    end
    chk("full_pop_empty", 64'(m_axis_tvalid), 64'd0);

    // Reset mid-frame and mid-pair
    do_reset();
    enable = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 16'(16'h0300 + i);
      step();
    end
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_data = 16'(16'h0310 + i);
      step();
    end
    chk("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    enable = 1'b0;
    do_reset();
    chk("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    enable = 1'b1; m_axis_tready = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      s_data = 16'(16'h0400 + i);
      step();
      if (m_axis_tvalid) begin
        chk("new_frame_tdata", 64'(m_axis_tdata), 64'({16'(16'h0400 + 2*k + 1), 16'(16'h0400 + 2*k)}));
        chk("new_frame_tlast", 64'(m_axis_tlast), 64'(k == 3));
        k++;
      end
    end
    enable = 1'b0;
    chk("new_frame_count", 64'(k), 64'd4);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
